bitwise_lane_unit: RTL and testbench

//   Parametrised, multi-cycle bitwise logic unit for the ALU datapath.
//   - Performs AND/OR/XOR/NOR on two WIDTH-bit operands, one group of

---
 rtl/alu_logic_pkg.sv | 16 +
 rtl/lane_logic.sv | 24 ++
 rtl/bitwise_lane_unit.sv | 124 ++++++++++++
 tb/tb_bitwise_lane_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_logic_pkg.sv
// Shared encodings for the lane-serial bitwise logic unit.
// Op codes and FSM states used by the top and its lane slices.
package alu_logic_pkg;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;
  localparam logic [1:0] LOGIC_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lane_logic.sv
// One combinational lane slice of the bitwise unit.
// Computes AND/OR/XOR/NOR of a and b for a single lane.
module lane_logic
  import alu_logic_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [1:0]        op,
  output logic [LANE_W-1:0] s
);

  always_comb begin
    s = '0;
    unique case (op)
      LOGIC_AND: s = a & b;
      LOGIC_OR:  s = a | b;
      LOGIC_XOR: s = a ^ b;
      LOGIC_NOR: s = ~(a | b);
    endcase
  end

endmodule

// File: rtl/bitwise_lane_unit.sv
// Multi-cycle bitwise logic unit: one lane group per BUSY cycle,
// valid/ready handshake on operands and on the result.
module bitwise_lane_unit
  import alu_logic_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int LANE_W        = 8,
  parameter int LANES_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int NUM_LANES = WIDTH / LANE_W;
  localparam int NUM_STEPS = NUM_LANES / LANES_PER_CYC;
  localparam int GRP_W     = LANES_PER_CYC * LANE_W;
  localparam int CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_STEPS - 1);

  if ((LANE_W < 1) || (LANES_PER_CYC < 1) ||
      (WIDTH % LANE_W != 0) ||
      (NUM_LANES % LANES_PER_CYC != 0)) begin : g_bad_params
    $error("bitwise_lane_unit: illegal WIDTH/LANE_W/LANES_PER_CYC");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic [GRP_W-1:0] la, lb, ls;

  // Lane group selected by the step counter; groups are contiguous.
  always_comb begin
    la = x_q[cnt_q*GRP_W +: GRP_W];
    lb = y_q[cnt_q*GRP_W +: GRP_W];
  end

  for (genvar g = 0; g < LANES_PER_CYC; g++) begin : g_lane
    lane_logic #(.LANE_W(LANE_W)) u_lane (
      .a  (la[g*LANE_W +: LANE_W]),
      .b  (lb[g*LANE_W +: LANE_W]),
      .op (op_q),
      .s  (ls[g*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          op_d    = op;
          res_d   = '0;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        res_d[cnt_q*GRP_W +: GRP_W] = ls;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          zero_d  = ~|res_d;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign result    = res_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bitwise_lane_unit.sv
// Bench for bitwise_lane_unit: three parameterisations run in lockstep
// against a whole-word reference model.
module tb_bitwise_lane_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [63:0] x_in = '0;
  logic [63:0] y_in = '0;

  logic        rdy_a, ov_a, z_a, busy_a;
  logic [31:0] res_a;
  logic        rdy_b, ov_b, z_b, busy_b;
  logic [31:0] res_b;
  logic        rdy_c, ov_c, z_c, busy_c;
  logic [63:0] res_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bitwise_lane_unit u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .op(op), .x(x_in[31:0]), .y(y_in[31:0]), .out_valid(ov_a),
    .out_ready(out_ready), .result(res_a), .zero(z_a), .busy(busy_a)
  );

  bitwise_lane_unit #(.WIDTH(32), .LANE_W(8), .LANES_PER_CYC(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .op(op), .x(x_in[31:0]), .y(y_in[31:0]), .out_valid(ov_b),
    .out_ready(out_ready), .result(res_b), .zero(z_b), .busy(busy_b)
  );

  bitwise_lane_unit #(.WIDTH(64), .LANE_W(16), .LANES_PER_CYC(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
    .op(op), .x(x_in), .y(y_in), .out_valid(ov_c),
    .out_ready(out_ready), .result(res_c), .zero(z_c), .busy(busy_c)
  );

  function automatic logic [63:0] ref_op(input logic [1:0] o,
                                         input logic [63:0] a,
                                         input logic [63:0] b,
                                         input int w);
    logic [63:0] r;
    case (o)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~(a | b);
    endcase
    if (w < 64) r = r & ((64'd1 << w) - 64'd1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input int hold,
                       input bit iso);
    int la, lb, lc;
    logic [63:0] ea, eb, ec;
    ea = ref_op(o, a, b, 32);
    eb = ea;
    ec = ref_op(o, a, b, 64);
    @(negedge clk);
    op = o; x_in = a; y_in = b;
    in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_a", rdy_a, 1);
    chk("in_ready_c", rdy_c, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (iso) begin
      op = ~o; x_in = ~a; y_in = a ^ b; in_valid = 1'b1;
      chk("iso_busy_a", busy_a, 1);
    end
    la = -1; lb = -1; lc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ov_a && la < 0) la = k;
      if (ov_b && lb < 0) lb = k;
      if (ov_c && lc < 0) lc = k;
      if (la >= 0 && lb >= 0 && lc >= 0) break;
    end
    in_valid = 1'b0;
    chk("latency_a", 64'(la), 4);
    chk("latency_b", 64'(lb), 1);
    chk("latency_c", 64'(lc), 2);
    chk("result_a", res_a, ea);
    chk("result_b", res_b, eb);
    chk("result_c", res_c, ec);
    chk("zero_a", z_a, (ea == 0));
    chk("zero_b", z_b, (eb == 0));
    chk("zero_c", z_c, (ec == 0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", ov_a, 1);
      chk("hold_ready", rdy_a, 0);
      chk("hold_result", res_a, ea);
      chk("hold_zero", z_a, (ea == 0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("consume_valid", ov_a, 0);
    chk("consume_ready", rdy_a, 1);
    chk("consume_ready_c", rdy_c, 1);
    if (iso) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("iso_no_capture", busy_a | ov_a, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", rdy_a, 1);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_result", res_a, 0);
    chk("rst_zero", z_a, 0);

    // Reset while mid-operation must abort it without a late completion.
    op = 2'd1; x_in = 64'hFFFF0000_FFFF0000; y_in = '0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", ov_a, 0);
    chk("midrst_result", res_a, 0);
    chk("midrst_busy", busy_a, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", rdy_a, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", ov_a | ov_c, 0);
    end

    do_op(2'd1, {2{32'h12345678}}, {2{32'h0F0F0000}}, 0, 1'b0);
    chk("or_literal", res_a, 32'h1F3F5678);
    do_op(2'd3, {2{32'hFFFFFFFF}}, 64'd0, 0, 1'b0);
    do_op(2'd0, {2{32'hF0F0F0F0}}, {2{32'h0F0F0F0F}}, 0, 1'b0);
    do_op(2'd2, {2{32'hAAAA5555}}, {2{32'hFFFF0000}}, 5, 1'b0);
    chk("xor_literal", res_a, 32'h55555555);
    do_op(2'd2, 64'h0123456789ABCDEF, 64'h00FF00FF00FF00FF, 1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [63:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 0) rb = ra;
      do_op(ro, ra, rb, i % 3, (i % 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
